// File: rtl/rr_mux_arbiter.sv
// Round-robin 8:1 arbiter with a registered output word.
// A new word can be captured whenever the output register is empty or being accepted.
module rr_mux_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          req,
  input  logic [8*DATA_W-1:0] din,
  input  logic                out_ready,
  output logic [7:0]          gnt,
  output logic [2:0]          sel,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] pick;
  logic [2:0] idx;
  logic       hit;
  logic       cap;

  // First asserted request at or after ptr, wrapping mod 8.
  always_comb begin
    pick = ptr;
    hit  = 1'b0;
    idx  = ptr;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!hit && req[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  assign cap = hit && (state == IDLE || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      gnt       <= '0;
      sel       <= '0;
      out_data  <= '0;
      ptr       <= '0;
    end else begin
      gnt <= '0;
      if (cap) begin
        state     <= HOLD;
        out_valid <= 1'b1;
        sel       <= pick;
        out_data  <= din[int'(pick)*DATA_W +: DATA_W];
        gnt       <= 8'(1) << pick;
        ptr       <= pick + 3'd1;
      end else if (state == HOLD && out_ready) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus a random run
// checked against a behavioural round-robin model.
module tb_rr_mux_arbiter;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     req = '0;
  logic [8*W-1:0] din = '0;
  logic           out_ready = 1'b0;
  logic [7:0]     gnt;
  logic [2:0]     sel;
  logic           out_valid;
  logic [W-1:0]   out_data;

  int n_cmp = 0;
  int n_err = 0;

  int         m_ptr;
  bit         m_valid;
  logic [7:0] m_data;
  logic [2:0] m_sel;
  logic [7:0] m_gnt;
  int         acc;

  rr_mux_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .out_ready(out_ready), .gnt(gnt), .sel(sel),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lane(logic [8*W-1:0] d, int k);
    return d[k*W +: W];
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = 0; m_sel = 0; m_gnt = 0;
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic tick(input logic [7:0] r, input logic [8*W-1:0] d,
                      input logic o);
    int k;
    req = r; din = d; out_ready = o;
    if (m_valid && o) acc++;
    k = -1;
    for (int i = 0; i < 8; i++)
      if (k < 0 && r[(m_ptr + i) % 8]) k = (m_ptr + i) % 8;
    m_gnt = 0;
    if (k >= 0 && (!m_valid || o)) begin
      m_sel = 3'(k); m_data = lane(d, k); m_gnt = 8'(1 << k);
      m_ptr = (k + 1) % 8; m_valid = 1;
    end else if (m_valid && o) begin
      m_valid = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; req = 0; out_ready = 0;
    #2 rst_n = 1;
    model_reset();
  endtask

  task automatic cmp_model(input string nm);
    n_cmp++;
    if ({gnt, sel, out_valid, out_data} !== {m_gnt, m_sel, m_valid, m_data}) begin
      n_err++;
      $display("FAIL %s: got gnt=%h sel=%0d v=%b d=%h want gnt=%h sel=%0d v=%b d=%h",
               nm, gnt, sel, out_valid, out_data, m_gnt, m_sel, m_valid, m_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; #3;
    n_cmp++;
    if ({gnt, sel, out_valid, out_data} !== '0) begin
      n_err++;
      $display("FAIL reset: got gnt=%h sel=%0d v=%b d=%h want all 0",
               gnt, sel, out_valid, out_data);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_walk();
    logic [8*W-1:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom};
      tick(8'hFF, d, 1'b1);
      n_cmp++;
      if (gnt !== 8'(1 << i) || sel !== 3'(i) || out_valid !== 1'b1 ||
          out_data !== lane(d, i)) begin
        n_err++;
        $display("FAIL walk[%0d]: got gnt=%h sel=%0d v=%b d=%h want gnt=%h sel=%0d v=1",
                 i, gnt, sel, out_valid, out_data, 8'(1 << i), i);
      end
    end
  endtask

  task automatic test_alternate();
    int exp_k;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_k = (i % 2 == 0) ? 2 : 5;
      tick(8'h24, {$urandom, $urandom}, 1'b1);
      n_cmp++;
      if (gnt !== 8'(1 << exp_k) || sel !== 3'(exp_k)) begin
        n_err++;
        $display("FAIL alt[%0d]: got gnt=%h sel=%0d want gnt=%h sel=%0d",
                 i, gnt, sel, 8'(1 << exp_k), exp_k);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] held;
    do_reset();
    tick(8'h08, {$urandom, $urandom}, 1'b0);
    held = out_data;
    cmp_model("stall_cap");
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      tick(8'($urandom), {$urandom, $urandom}, 1'b0);
      n_cmp++;
      if (gnt !== 8'h00 || sel !== 3'd3 || out_valid !== 1'b1 ||
          out_data !== held) begin
        n_err++;
        $display("FAIL stall[%0d]: got gnt=%h sel=%0d v=%b d=%h want gnt=00 sel=3 v=1 d=%h",
                 i, gnt, sel, out_valid, out_data, held);
      end
    end
    tick(8'h00, {$urandom, $urandom}, 1'b1);
    tick(8'h00, {$urandom, $urandom}, 1'b1);
    n_cmp++;
    if (acc !== 1 || out_valid !== 1'b0 || sel !== 3'd3 || out_data !== held) begin
      n_err++;
      $display("FAIL stall_drain: got acc=%0d v=%b sel=%0d d=%h want acc=1 v=0 sel=3 d=%h",
               acc, out_valid, sel, out_data, held);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(8'h80, {$urandom, $urandom}, 1'b1);
    cmp_model("wrap_7");
    tick(8'h81, {$urandom, $urandom}, 1'b1);
    n_cmp++;
    if (sel !== 3'd0 || gnt !== 8'h01) begin
      n_err++;
      $display("FAIL wrap_0: got sel=%0d gnt=%h want sel=0 gnt=01", sel, gnt);
    end
    tick(8'h81, {$urandom, $urandom}, 1'b1);
    n_cmp++;
    if (sel !== 3'd7 || gnt !== 8'h80) begin
      n_err++;
      $display("FAIL wrap_7b: got sel=%0d gnt=%h want sel=7 gnt=80", sel, gnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(8'h01, 64'h00000000_000000A5, 1'b0);
    n_cmp++;
    if (out_data !== 8'hA5 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pre: got v=%b d=%h want v=1 d=a5", out_valid, out_data);
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || gnt !== 8'h00 || sel !== 3'd0) begin
      n_err++;
      $display("FAIL arst_now: got v=%b d=%h gnt=%h sel=%0d want all 0",
               out_valid, out_data, gnt, sel);
    end
    #1 rst_n = 1;
    model_reset();
    req = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (gnt !== 8'h00 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL arst_exit: got gnt=%h v=%b want gnt=00 v=0", gnt, out_valid);
    end
    tick(8'h10, {$urandom, $urandom}, 1'b1);
    n_cmp++;
    if (sel !== 3'd4 || gnt !== 8'h10 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL arst_after: got sel=%0d gnt=%h v=%b want sel=4 gnt=10 v=1",
               sel, gnt, out_valid);
    end
  endtask

  task automatic test_single();
    logic [8*W-1:0] d;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, $urandom};
      tick(8'h40, d, 1'b1);
      n_cmp++;
      if (gnt !== 8'h40 || sel !== 3'd6 || out_valid !== 1'b1 ||
          out_data !== lane(d, 6)) begin
        n_err++;
        $display("FAIL single[%0d]: got gnt=%h sel=%0d v=%b d=%h want gnt=40 sel=6 v=1 d=%h",
                 i, gnt, sel, out_valid, out_data, lane(d, 6));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = ($urandom % 5 == 0) ? 8'h00 : 8'($urandom & $urandom);
      tick(r, {$urandom, $urandom}, ($urandom % 4) != 0);
      cmp_model("random");
    end
  endtask

  initial begin
    model_reset();
    acc = 0;
    test_reset();
    test_walk();
    test_alternate();
    test_stall();
    test_wrap();
    test_async_reset();
    test_single();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of each requester data lane.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  8  per-requester level request, bit k = requester k.
REQ-005 SHALL have port din  input  8*DATA_W  requester data, lane k = din[k*DATA_W +: DATA_W].
REQ-006 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-007 SHALL have port gnt  output  8  one-hot, one-cycle pulse marking the requester whose lane was captured.
REQ-008 SHALL have port sel  output  3  index of the currently or last granted requester; drives the 8:1 mux select.
REQ-009 SHALL have port out_valid  output  1  out_data holds an unaccepted word.
REQ-010 SHALL have port out_data  output  DATA_W  captured data of requester sel.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-012 SHALL keep a 3-bit priority pointer ptr; the search order is ptr, ptr+1, ..., ptr+7, mod 8.
REQ-013 SHALL define "capture" as: choose the first asserted req bit k in search order; register sel<=k, out_data<=lane k, gnt<=one-hot(k) for one cycle, ptr<=(k+1) mod 8.
REQ-014 SHALL capture in IDLE on any cycle with req!=0, and move to HOLD.
REQ-015 SHALL, in HOLD, keep out_valid, out_data and sel stable until out_valid&&out_ready.
REQ-016 SHALL, in HOLD with out_ready=1 and req!=0, capture a new word in the same cycle and stay in HOLD, giving a throughput of one word per cycle.
REQ-017 SHALL, in HOLD with out_ready=1 and req=0, go to IDLE with out_valid=0; out_data and sel keep their last values.
REQ-018 SHALL hold gnt at 0 except in the cycle after a capture; at most one gnt bit is ever set.
REQ-019 SHALL give a latency of one cycle from req sampled in IDLE to out_valid=1.
REQ-020 SHALL apply this rule to requesters: a requester deasserts or updates req/din in the cycle it sees its gnt bit; the block samples req combinationally in the capture cycle.
REQ-021 SHALL wrap the pointer: a grant to requester 7 sets ptr=0.
REQ-022 SHALL grant a requester again when it is the only one asserting req, with no bubble.
REQ-023 SHALL not react to req changes in HOLD while out_ready=0: there is no capture and no gnt.
REQ-024 SHALL treat out_ready as a don't-care in IDLE.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force state=IDLE, out_valid=0, gnt=0, sel=0, out_data=0 and ptr=0.
REQ-026 SHALL, on reset asserted in HOLD, discard the pending word, with no gnt on exit.
REQ-027 SHALL make the first capture after rst_n deassertion give requester 0 highest priority.

Verification
REQ-028 SHALL verify: after reset, req=8'hFF and out_ready=1 held for 8 cycles -> gnt walks 01,02,04,...,80 and sel walks 0..7, with out_valid high from cycle 1.
REQ-029 SHALL verify: req=8'h24 (bits 2,5) and out_ready=1 -> grants alternate 2,5,2,5; sel=2 then 5.
REQ-030 SHALL verify: capture of requester 3 with out_ready=0 for 4 cycles while req changes -> out_data and sel=3 stay stable, gnt stays 0, and exactly one word is accepted when out_ready rises.
REQ-031 SHALL verify wrap: last grant 7, then req=8'h81 -> next grant is 0, then 7.
REQ-032 SHALL verify: rst_n pulsed low mid-HOLD with out_data=8'hA5 -> out_valid=0 and out_data=0 immediately, without waiting for clk; after release, req=8'h10 -> sel=4.
REQ-033 SHALL verify: single requester 6 holding req with out_ready=1 -> gnt[6] pulses every cycle, with no idle cycle between words.
